// File: rtl/wb4_ram_slave_if.sv
// Wishbone B4 pipelined bus bundle shared by the RAM slave and its master.
// state_dbg carries the slave's FSM state so checkers can observe it directly.
interface WB4;
    logic        clk;
    logic        rst;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [31:0] ADR;
    logic [3:0]  SEL;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        ERR;
    logic        STALL;
    logic [1:0]  state_dbg;

    modport slave (
        input  clk, rst, CYC, STB, WE, ADR, SEL, DAT_I,
        output DAT_O, ACK, ERR, STALL, state_dbg
    );

    modport master (
        input  clk, rst, DAT_O, ACK, ERR, STALL, state_dbg,
        output CYC, STB, WE, ADR, SEL, DAT_I
    );
endinterface

// File: rtl/wb4_ram_slave.sv
// Single-port 32-bit Wishbone B4 RAM slave with a programmable number of wait states.
// Handshake: a request is taken when CYC&STB are high while STALL is low; it ends with exactly one ACK or ERR pulse.
module wb4_ram_slave #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    WB4.slave bus
);
    localparam int         AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0] WS   = 4'(WAIT_STATES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;
    logic          err_q;
    logic          ack_r;
    logic          err_r;
    logic [31:0]   dat_o_r;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic          in_range;
    logic          req_err;
    logic [AW-1:0] idx_c;
    logic          accept;
    logic          enter_resp;
    logic [AW-1:0] acc_idx;
    logic          acc_we;
    logic          acc_err;
    logic [3:0]    acc_sel;
    logic [31:0]   acc_dat;

    always_comb begin
        off        = bus.ADR - BASE_ADDR;
        in_range   = (bus.ADR >= BASE_ADDR) && ({1'b0, off} < SPAN);
        req_err    = (bus.ADR[1:0] != 2'b00) || !in_range;
        idx_c      = off[AW+1:2];
        accept     = (state == IDLE) && bus.CYC && bus.STB;
        enter_resp = (accept && (WS == 4'd0)) ||
                     ((state == WAIT) && bus.CYC && (cnt == 4'd1));
        // With zero wait states RESP is entered on the accepting edge, so the live request is used.
        if (state == IDLE) begin
            acc_idx = idx_c;
            acc_we  = bus.WE;
            acc_err = req_err;
            acc_sel = bus.SEL;
            acc_dat = bus.DAT_I;
        end else begin
            acc_idx = idx_q;
            acc_we  = we_q;
            acc_err = err_q;
            acc_sel = sel_q;
            acc_dat = dat_q;
        end
    end

    always_ff @(posedge bus.clk) begin
        if (bus.rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            dat_o_r <= 32'h0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q <= idx_c;
                        we_q  <= bus.WE;
                        sel_q <= bus.SEL;
                        dat_q <= bus.DAT_I;
                        err_q <= req_err;
                        cnt   <= WS;
                        state <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (!bus.CYC) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                ack_r <= !acc_err;
                err_r <= acc_err;
                if (!acc_we && !acc_err)
                    dat_o_r <= mem[acc_idx];
            end
        end
    end

    // Memory has no reset; a reset on the RESP-entry edge suppresses the write.
    always_ff @(posedge bus.clk) begin
        if (!bus.rst && enter_resp && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b])
                    mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
            end
        end
    end

    assign bus.DAT_O     = dat_o_r;
    assign bus.ACK       = ack_r;
    assign bus.ERR       = err_r;
    assign bus.STALL     = (state != IDLE);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_wb4_ram_slave.sv
// Bench for wb4_ram_slave: three instances (1, 3 and 0 wait states) share one master,
// with CYC routed only to the selected instance and its outputs muxed back.
module tb_wb4_ram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dsel;
    logic        cyc, stb, we_m;
    logic [31:0] adr_m, dat_m;
    logic [3:0]  sel_m;
    logic        ack_m, err_m, stall_m;
    logic [31:0] dout_m;
    logic [1:0]  st_m;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];
    logic [31:0] last_rd[3];

    always #5 clk = ~clk;

    WB4 b0();
    WB4 b1();
    WB4 b2();

    assign b0.clk = clk;  assign b1.clk = clk;  assign b2.clk = clk;
    assign b0.rst = rst;  assign b1.rst = rst;  assign b2.rst = rst;
    assign b0.CYC = cyc && (dsel == 2'd0);
    assign b1.CYC = cyc && (dsel == 2'd1);
    assign b2.CYC = cyc && (dsel == 2'd2);
    assign b0.STB = stb;  assign b1.STB = stb;  assign b2.STB = stb;
    assign b0.WE = we_m;  assign b1.WE = we_m;  assign b2.WE = we_m;
    assign b0.ADR = adr_m; assign b1.ADR = adr_m; assign b2.ADR = adr_m;
    assign b0.SEL = sel_m; assign b1.SEL = sel_m; assign b2.SEL = sel_m;
    assign b0.DAT_I = dat_m; assign b1.DAT_I = dat_m; assign b2.DAT_I = dat_m;

    wb4_ram_slave #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(1)) u_ws1 (.bus(b0));
    wb4_ram_slave #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) u_ws3 (.bus(b1));
    wb4_ram_slave #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_ws0 (.bus(b2));

    always_comb begin
        ack_m = 1'b0; err_m = 1'b0; stall_m = 1'b0; dout_m = 32'h0; st_m = 2'd0;
        case (dsel)
            2'd0: begin ack_m = b0.ACK; err_m = b0.ERR; stall_m = b0.STALL; dout_m = b0.DAT_O; st_m = b0.state_dbg; end
            2'd1: begin ack_m = b1.ACK; err_m = b1.ERR; stall_m = b1.STALL; dout_m = b1.DAT_O; st_m = b1.state_dbg; end
            default: begin ack_m = b2.ACK; err_m = b2.ERR; stall_m = b2.STALL; dout_m = b2.DAT_O; st_m = b2.state_dbg; end
        endcase
    end

    typedef struct {
        logic [1:0]  k;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[19];

    function automatic int ws_of(input logic [1:0] k);
        case (k)
            2'd0:    return 1;
            2'd1:    return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] pre(input int k, input int i);
        return 32'h5A00_0000 | 32'(k << 8) | 32'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic transact(input logic [1:0] k, input logic we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat,
                            input logic exp_err, input logic [31:0] exp_rd);
        logic [32:0] exp_v;
        int n;
        exp_q.push_back({exp_err, (exp_err || we) ? last_rd[k] : exp_rd});
        if (!exp_err && !we) last_rd[k] = exp_rd;
        @(negedge clk);
        dsel = k; cyc = 1'b1; stb = 1'b1; we_m = we; adr_m = adr; sel_m = sel; dat_m = dat;
        @(posedge clk);
        #1;
        stb = 1'b0; we_m = ~we; adr_m = 32'hFFFF_FFF2; sel_m = ~sel; dat_m = ~dat;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (ack_m || err_m) break;
        end
        exp_v = exp_q.pop_front();
        if (!(ack_m || err_m)) begin
            check("response_timeout", 64'(0), 64'(1));
        end else begin
            check("ack_err_exclusive", 64'(ack_m && err_m), 64'(0));
            check("latency", 64'(n), 64'(ws_of(k) + 1));
            check("response", 64'({err_m, dout_m}), 64'(exp_v));
        end
        cyc = 1'b0;
    endtask

    initial begin : main
        logic quiet;
        rst = 1'b1; dsel = 2'd0; cyc = 1'b0; stb = 1'b0; we_m = 1'b0;
        adr_m = 32'h0; sel_m = 4'h0; dat_m = 32'h0;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            dsel = 2'(k);
            #1;
            check("reset_outputs", 64'({ack_m, err_m, stall_m, st_m, dout_m}), 64'(0));
        end

        // STB without CYC must be ignored.
        @(negedge clk);
        dsel = 2'd0; stb = 1'b1; we_m = 1'b1; adr_m = 32'h1000; sel_m = 4'hF; dat_m = 32'h1;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ack_m || err_m || stall_m) quiet = 1'b0;
        end
        stb = 1'b0;
        check("stb_without_cyc", 64'(quiet), 64'(1));

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++)
                transact(2'(k), 1'b1, 32'h1000 + 32'(4 * i), 4'hF, pre(k, i), 1'b0, 32'h0);

        vt[0]  = '{2'd0, 1'b1, 32'h1008, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[1]  = '{2'd0, 1'b0, 32'h1008, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{2'd0, 1'b1, 32'h100C, 4'hF, 32'h11223344, 1'b0, 32'h0};
        vt[3]  = '{2'd0, 1'b1, 32'h100C, 4'h2, 32'h0000AA00, 1'b0, 32'h0};
        vt[4]  = '{2'd0, 1'b0, 32'h100C, 4'h0, 32'h0,        1'b0, 32'h1122AA44};
        vt[5]  = '{2'd0, 1'b0, 32'h1002, 4'hF, 32'h0,        1'b1, 32'h0};
        vt[6]  = '{2'd0, 1'b1, 32'h1040, 4'hF, 32'h0BADF00D, 1'b1, 32'h0};
        vt[7]  = '{2'd0, 1'b0, 32'h0FFC, 4'hF, 32'h0,        1'b1, 32'h0};
        vt[8]  = '{2'd0, 1'b1, 32'h1004, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[9]  = '{2'd0, 1'b0, 32'h1004, 4'hF, 32'h0,        1'b0, 32'h5A000001};
        vt[10] = '{2'd0, 1'b0, 32'h103C, 4'hF, 32'h0,        1'b0, 32'h5A00000F};
        vt[11] = '{2'd0, 1'b1, 32'h1000, 4'h9, 32'hAABBCCDD, 1'b0, 32'h0};
        vt[12] = '{2'd0, 1'b1, 32'h1002, 4'hF, 32'h12345678, 1'b1, 32'h0};
        vt[13] = '{2'd0, 1'b0, 32'h1000, 4'hF, 32'h0,        1'b0, 32'hAA0000DD};
        vt[14] = '{2'd2, 1'b1, 32'h1010, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
        vt[15] = '{2'd2, 1'b0, 32'h1010, 4'hF, 32'h0,        1'b0, 32'hCAFEF00D};
        vt[16] = '{2'd1, 1'b0, 32'h1004, 4'hF, 32'h0,        1'b0, 32'h5A000101};
        vt[17] = '{2'd1, 1'b1, 32'h1008, 4'hF, 32'h13579BDF, 1'b0, 32'h0};
        vt[18] = '{2'd1, 1'b0, 32'h1008, 4'hF, 32'h0,        1'b0, 32'h13579BDF};

        for (int i = 0; i < 19; i++)
            transact(vt[i].k, vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, vt[i].exp_err, vt[i].exp_rd);

        // Three wait states, CYC dropped one cycle after the write is accepted.
        @(negedge clk);
        dsel = 2'd1; cyc = 1'b1; stb = 1'b1; we_m = 1'b1; adr_m = 32'h1008; sel_m = 4'hF; dat_m = 32'h99999999;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ack_m || err_m) quiet = 1'b0;
        end
        check("abort_no_response", 64'(quiet), 64'(1));
        check("abort_state_idle", 64'(st_m), 64'(0));
        transact(2'd1, 1'b0, 32'h1008, 4'hF, 32'h0, 1'b0, 32'h13579BDF);

        // Zero wait states with STB held: ACK on alternate cycles, STALL during RESP.
        @(negedge clk);
        dsel = 2'd2; cyc = 1'b1; stb = 1'b1; we_m = 1'b0; adr_m = 32'h1010; sel_m = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("b2b_ack", 64'(ack_m), 64'(i % 2));
            check("b2b_stall", 64'(stall_m), 64'(i % 2));
            if (i % 2 == 1) check("b2b_data", 64'(dout_m), 64'(32'hCAFEF00D));
        end
        cyc = 1'b0; stb = 1'b0;

        // Reset during the WAIT of a write.
        @(negedge clk);
        dsel = 2'd0; cyc = 1'b1; stb = 1'b1; we_m = 1'b1; adr_m = 32'h1010; sel_m = 4'hF; dat_m = 32'h77777777;
        @(negedge clk);
        check("pre_reset_in_wait", 64'(st_m), 64'(1));
        rst = 1'b1; stb = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", 64'({ack_m, err_m, stall_m, dout_m}), 64'(0));
        rst = 1'b0; cyc = 1'b0;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack_m || err_m) quiet = 1'b0;
        end
        check("post_reset_quiet", 64'(quiet), 64'(1));
        transact(2'd0, 1'b0, 32'h1010, 4'hF, 32'h0, 1'b0, 32'h5A000004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
